// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush scheduler for the five-stage core
// Codes are combinational from state and inputs; only sequencing state and counters are registered.
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_busy,
    input  logic        id_load_use,
    input  logic        ex_redirect,
    input  logic        me_mem_req,
    input  logic        mem_ready,
    input  logic        wb_trap,
    output logic [1:0]  stall_pc,
    output logic [1:0]  stall_if_id,
    output logic [1:0]  stall_id_ex,
    output logic [1:0]  stall_ex_me,
    output logic [1:0]  stall_me_wb,
    output logic        trap_commit,
    output logic        mem_timeout,
    output logic [63:0] stall_cycles
);

    localparam logic [1:0] NEXT = 2'b00;
    localparam logic [1:0] KEEP = 2'b01;
    localparam logic [1:0] ZERO = 2'b10;
    localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] wait_cnt;
    logic        mstall;

    assign mstall = me_mem_req & ~mem_ready;

    always_comb begin
        stall_pc    = NEXT;
        stall_if_id = NEXT;
        stall_id_ex = NEXT;
        stall_ex_me = NEXT;
        stall_me_wb = NEXT;
        trap_commit = 1'b0;
        state_next  = RUN;
        if (rst) begin
            stall_pc    = ZERO;
            stall_if_id = ZERO;
            stall_id_ex = ZERO;
            stall_ex_me = ZERO;
            stall_me_wb = ZERO;
        end else if (state == DRAIN) begin
            // The trapping instruction sits in WB until the outstanding access returns.
            stall_if_id = ZERO;
            stall_id_ex = ZERO;
            stall_ex_me = ZERO;
            if (mem_ready) begin
                stall_me_wb = ZERO;
                trap_commit = 1'b1;
            end else begin
                stall_pc    = KEEP;
                stall_me_wb = KEEP;
                state_next  = DRAIN;
            end
        end else if (wb_trap) begin
            stall_if_id = ZERO;
            stall_id_ex = ZERO;
            stall_ex_me = ZERO;
            if (mstall) begin
                stall_pc    = KEEP;
                stall_me_wb = KEEP;
                state_next  = DRAIN;
            end else begin
                stall_me_wb = ZERO;
                trap_commit = 1'b1;
            end
        end else if (mstall) begin
            stall_pc    = KEEP;
            stall_if_id = KEEP;
            stall_id_ex = KEEP;
            stall_ex_me = KEEP;
            stall_me_wb = ZERO;
            state_next  = MEM_WAIT;
        end else if (ex_redirect) begin
            stall_if_id = ZERO;
            stall_id_ex = ZERO;
        end else if (id_load_use) begin
            stall_pc    = KEEP;
            stall_if_id = KEEP;
            stall_id_ex = ZERO;
        end else if (if_busy) begin
            stall_pc    = KEEP;
            stall_if_id = ZERO;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            wait_cnt     <= 16'd0;
            mem_timeout  <= 1'b0;
            stall_cycles <= 64'd0;
        end else begin
            state <= state_next;
            if (state == RUN) begin
                wait_cnt <= 16'd0;
            end else if (!mem_ready && wait_cnt != TIMEOUT) begin
                wait_cnt <= wait_cnt + 16'd1;
                if (wait_cnt + 16'd1 == TIMEOUT) begin
                    mem_timeout <= 1'b1;
                end
            end
            if (stall_pc == KEEP) begin
                stall_cycles <= stall_cycles + 64'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed and random checks of pipe_ctrl against a rule-table model
module tb_pipe_ctrl;

    localparam int TO = 4;
    localparam logic [1:0] N = 2'b00, K = 2'b01, Z = 2'b10;

    logic        clk = 1'b0;
    logic        rst, if_busy, id_load_use, ex_redirect, me_mem_req, mem_ready, wb_trap;
    logic [1:0]  stall_pc, stall_if_id, stall_id_ex, stall_ex_me, stall_me_wb;
    logic        trap_commit, mem_timeout;
    logic [63:0] stall_cycles;

    int vectors = 0;
    int miscompares = 0;

    // Model: whether a trap is pending behind memory, a count of wait cycles, sticky timeout, stall count.
    bit              m_trap_pending;
    bit              m_waiting;
    int              m_waits;
    bit              m_to;
    longint unsigned m_stalls;

    always #5 clk = ~clk;

    pipe_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .if_busy(if_busy), .id_load_use(id_load_use),
        .ex_redirect(ex_redirect), .me_mem_req(me_mem_req), .mem_ready(mem_ready),
        .wb_trap(wb_trap), .stall_pc(stall_pc), .stall_if_id(stall_if_id),
        .stall_id_ex(stall_id_ex), .stall_ex_me(stall_ex_me), .stall_me_wb(stall_me_wb),
        .trap_commit(trap_commit), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply(input bit r, input bit ib, input bit lu, input bit rd,
                         input bit mq, input bit mr, input bit tr);
        logic [9:0] exp_codes;
        bit         exp_tc;
        bit         stall;
        bit         next_pending, next_waiting;
        @(negedge clk);
        rst = r; if_busy = ib; id_load_use = lu; ex_redirect = rd;
        me_mem_req = mq; mem_ready = mr; wb_trap = tr;
        #1;
        stall = mq && !mr;
        exp_tc = 1'b0;
        next_pending = 1'b0;
        next_waiting = 1'b0;
        if (r)                        exp_codes = {Z, Z, Z, Z, Z};
        else if (m_trap_pending) begin
            if (mr) begin exp_codes = {N, Z, Z, Z, Z}; exp_tc = 1'b1; end
            else begin exp_codes = {K, Z, Z, Z, K}; next_pending = 1'b1; end
        end
        else if (tr && stall)       begin exp_codes = {K, Z, Z, Z, K}; next_pending = 1'b1; end
        else if (tr)                begin exp_codes = {N, Z, Z, Z, Z}; exp_tc = 1'b1; end
        else if (stall)             begin exp_codes = {K, K, K, K, Z}; next_waiting = 1'b1; end
        else if (rd)                  exp_codes = {N, Z, Z, N, N};
        else if (lu)                  exp_codes = {K, K, Z, N, N};
        else if (ib)                  exp_codes = {K, Z, N, N, N};
        else                          exp_codes = {N, N, N, N, N};

        check("codes", {stall_pc, stall_if_id, stall_id_ex, stall_ex_me, stall_me_wb}, exp_codes);
        check("trap_commit", trap_commit, exp_tc);
        check("mem_timeout", mem_timeout, m_to);
        check("stall_cycles", stall_cycles, m_stalls);

        if (r) begin
            m_trap_pending = 0; m_waiting = 0; m_waits = 0; m_to = 0; m_stalls = 0;
        end else begin
            if (!(m_trap_pending || m_waiting)) m_waits = 0;
            else if (!mr && m_waits < TO) begin
                m_waits++;
                if (m_waits == TO) m_to = 1;
            end
            if (exp_codes[9:8] == K) m_stalls++;
            m_trap_pending = next_pending;
            m_waiting = next_waiting;
        end
    endtask

    initial begin
        rst = 1; if_busy = 0; id_load_use = 0; ex_redirect = 0;
        me_mem_req = 0; mem_ready = 0; wb_trap = 0;
        m_trap_pending = 0; m_waiting = 0; m_waits = 0; m_to = 0; m_stalls = 0;

        apply(1, 0, 0, 0, 0, 0, 0);
        apply(1, 1, 1, 1, 1, 0, 1);

        // Load-use for one cycle.
        apply(0, 0, 1, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0);
        check("load_use_stalls", stall_cycles, 64'd1);

        // Three-cycle memory wait then release.
        apply(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) apply(0, 0, 0, 0, 1, 0, 0);
        apply(0, 0, 0, 0, 1, 1, 0);
        apply(0, 0, 0, 0, 0, 0, 0);
        check("mem_wait_stalls", stall_cycles, 64'd3);

        // Redirect held across a memory wait is honored on release.
        for (int i = 0; i < 2; i++) apply(0, 0, 0, 1, 1, 0, 0);
        apply(0, 0, 0, 1, 1, 1, 0);
        check("redirect_release", {stall_pc, stall_if_id, stall_id_ex, stall_ex_me, stall_me_wb},
              {N, Z, Z, N, N});

        // Trap without memory stall, then trap behind a memory stall.
        apply(0, 0, 0, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 0, 0, 0);
        check("no_double_commit", trap_commit, 1'b0);
        apply(0, 1, 1, 1, 1, 0, 1);
        apply(0, 1, 1, 1, 1, 0, 1);
        apply(0, 0, 0, 0, 1, 1, 1);
        check("drain_commit", trap_commit, 1'b1);
        apply(0, 0, 0, 0, 0, 0, 0);

        // Timeout: sticky until reset.
        for (int i = 0; i < TO + 2; i++) apply(0, 0, 0, 0, 1, 0, 0);
        check("timeout_set", mem_timeout, 1'b1);
        apply(0, 0, 0, 0, 1, 1, 0);
        apply(0, 0, 0, 0, 0, 0, 0);
        check("timeout_sticky", mem_timeout, 1'b1);
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0);
        check("timeout_cleared", mem_timeout, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(99) < 2, $urandom_range(99) < 30, $urandom_range(99) < 20,
                  $urandom_range(99) < 20, $urandom_range(99) < 50, $urandom_range(99) < 35,
                  $urandom_range(99) < 10);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
